// File: rtl/coprosit_pkg.sv
// Shared types for the Coprosit posit coprocessor result path.
// Sized for a 32-bit core with 4-bit eXtension-interface ids.
package coprosit_pkg;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFW_WIDTH = 32;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            addr;
    logic                  rd_is_pos;
  } prau_tag_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  dbg;
  } mem_metadata_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [5:0]             ecsdata;
    logic [2:0]             ecswe;
    logic                   exc;
    logic [5:0]             exccode;
    logic                   err;
    logic                   dbg;
  } x_result_t;

  typedef enum logic {
    SrcPrau = 1'b0,
    SrcMem  = 1'b1
  } result_src_e;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
  } preg_wr_t;

endpackage

// File: rtl/coprosit_result_skid.sv
// Two-entry in-order buffer of x_result_t behind the result output register.
// The owner never pushes when full nor pops when empty.
module coprosit_result_skid
  import coprosit_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      i_push,
  input  x_result_t i_data,
  input  logic      i_pop,
  output x_result_t o_head,
  output logic      o_empty,
  output logic      o_full
);

  x_result_t  r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

endmodule

// File: rtl/coprosit_result_arb.sv
// Round-robin merge of PRAU and memory completions into one registered result
// stream, plus the posit RF write. Optional skid: COPROSIT_RESULT_SKID_EN.
module coprosit_result_arb
  import coprosit_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          prau_valid_i,
  output logic          prau_ready_o,
  input  logic [31:0]   prau_result_i,
  input  prau_tag_t     prau_tag_i,
  input  logic          mem_valid_i,
  output logic          mem_ready_o,
  input  logic [31:0]   mem_rdata_i,
  input  mem_metadata_t mem_meta_i,
  input  logic          mem_err_i,
  output logic          preg_we_o,
  output logic [4:0]    preg_waddr_o,
  output logic [31:0]   preg_wdata_o,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o
);

  // Handshake: a channel transfers on a cycle where valid & ready; valid and
  // payload stay stable until then; ready may depend on valid.
  result_src_e r_rr;
  logic        r_valid;
  x_result_t   r_result;
  preg_wr_t    r_preg;

  logic        w_gnt_prau;
  logic        w_gnt_mem;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_out_load;
  logic        w_out_src_valid;
  x_result_t   w_out_src;
  x_result_t   w_new;
  preg_wr_t    w_new_preg;

  // r_rr names the preferred source when both are valid.
  assign w_gnt_prau   = prau_valid_i & (~mem_valid_i | (r_rr == SrcPrau));
  assign w_gnt_mem    = mem_valid_i & (~prau_valid_i | (r_rr == SrcMem));
  assign w_out_load   = ~r_valid | x_result_ready_i;
  assign prau_ready_o = w_gnt_prau & w_in_ready;
  assign mem_ready_o  = w_gnt_mem & w_in_ready;
  assign w_accept     = prau_ready_o | mem_ready_o;

  always_comb begin
    w_new      = '0;
    w_new_preg = '0;
    if (w_gnt_prau) begin
      w_new.id        = prau_tag_i.id;
      w_new.rd        = prau_tag_i.addr;
      w_new.data      = prau_result_i;
      w_new.we        = ~prau_tag_i.rd_is_pos;
      w_new_preg.addr = prau_tag_i.addr;
      w_new_preg.data = prau_result_i;
      w_new_preg.we   = prau_tag_i.rd_is_pos;
    end else begin
      w_new.id        = mem_meta_i.id;
      w_new.rd        = mem_meta_i.rd;
      w_new.data      = mem_rdata_i;
      w_new.exc       = mem_meta_i.exc;
      w_new.exccode   = mem_meta_i.exccode;
      w_new.dbg       = mem_meta_i.dbg;
      w_new.err       = mem_err_i;
      w_new_preg.addr = mem_meta_i.rd;
      w_new_preg.data = mem_rdata_i;
      w_new_preg.we   = mem_meta_i.we & ~mem_meta_i.exc & ~mem_err_i;
    end
  end

`ifdef COPROSIT_RESULT_SKID_EN
  logic      w_skid_full;
  logic      w_skid_empty;
  logic      w_push;
  logic      w_pop;
  x_result_t w_skid_head;

  // Buffered entries are older than the incoming one, so they drain first.
  assign w_in_ready      = ~w_skid_full;
  assign w_pop           = w_out_load & ~w_skid_empty;
  assign w_push          = w_accept & ~(w_out_load & w_skid_empty);
  assign w_out_src_valid = ~w_skid_empty | w_accept;
  assign w_out_src       = w_skid_empty ? w_new : w_skid_head;

  coprosit_result_skid u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (w_new),
    .i_pop   (w_pop),
    .o_head  (w_skid_head),
    .o_empty (w_skid_empty),
    .o_full  (w_skid_full)
  );
`else
  assign w_in_ready      = w_out_load;
  assign w_out_src_valid = w_accept;
  assign w_out_src       = w_new;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr     <= SrcPrau;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_preg   <= '0;
    end else begin
      if (w_accept) r_rr <= w_gnt_prau ? SrcMem : SrcPrau;
      if (w_out_load) begin
        r_valid <= w_out_src_valid;
        if (w_out_src_valid) r_result <= w_out_src;
      end
      if (w_accept) r_preg <= w_new_preg;
      else          r_preg.we <= 1'b0;
    end
  end

  assign x_result_valid_o = r_valid;
  assign x_result_o       = r_result;
  assign preg_we_o        = r_preg.we;
  assign preg_waddr_o     = r_preg.addr;
  assign preg_wdata_o     = r_preg.data;

endmodule
